multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage, alongside the ALU. It receives `ctrl_MULT`/`ctrl_DIV` start pulses when a mul/div instruction enters DX (ALU op 00110 / 00111). It produces `data_resultRDY`, which the pipeline stall logic waits on before releasing the pipeline. The result and exception go to the X/M register for writeback to rd, or to $rstatus on exception.

---
 rtl/multdiv_pkg.sv | 26 ++
 rtl/multdiv_abs_neg.sv | 35 +++
 rtl/multdiv_unit.sv | 173 +++++++++++++++++
 tb/tb_multdiv_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// ============================================================================
// Module : multdiv_pkg
// Brief  : Shared types and constants for the iterative multiply/divide unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITERS = 32;

  localparam logic [31:0] INT_MIN    = 32'h8000_0000;
  localparam logic [4:0]  ALU_OP_MUL = 5'b00110;
  localparam logic [4:0]  ALU_OP_DIV = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/multdiv_abs_neg.sv
// ============================================================================
// Module : multdiv_abs_neg
// Brief  : Magnitude/sign of a signed value, or conditional negate of a magnitude.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multdiv_abs_neg #(
  parameter int W     = 32,
  parameter int OUT_W = W + 1
) (
  input  logic [W-1:0]     i_value,
  input  logic             i_abs,
  input  logic             i_neg,
  output logic             o_sign,
  output logic [OUT_W-1:0] o_value
);

  logic [OUT_W-1:0] w_ext;

  // Sign extension keeps |-2^(W-1)| exact when one extra output bit is available.
  generate
    if (OUT_W > W) begin : g_sext
      assign w_ext = {{(OUT_W-W){i_value[W-1]}}, i_value};
    end else begin : g_same
      assign w_ext = i_value;
    end
  endgenerate

  assign o_sign  = i_abs ? i_value[W-1] : i_neg;
  assign o_value = o_sign ? -w_ext : w_ext;

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// Module : multdiv_unit
// Brief  : Iterative signed multiply (shift-add) / divide (restoring) unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITERS = MD_ITERS
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam int MAG_W = WIDTH + 1;
  localparam int ACC_W = 2 * WIDTH;

  md_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [MAG_W-1:0] r_mag_a, r_mag_b, r_rem;
  logic             r_sign;
  logic [ACC_W-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;

  logic             w_start, w_last, w_dz;
  logic [MAG_W-1:0] w_mag_a, w_mag_b;
  logic             w_sign_a, w_sign_b;
  logic [ACC_W-1:0] w_acc_mul, w_acc_div;
  logic [MAG_W:0]   w_rem_sh, w_rem_diff;
  logic [MAG_W-1:0] w_rem_nxt;
  logic             w_q_bit;
  logic [CNT_W-1:0] w_div_idx;
  logic [WIDTH-1:0] w_mag_res, w_res;
  logic             w_res_sign, w_mul_ovf, w_div_ovf;

  multdiv_abs_neg #(.W(WIDTH), .OUT_W(MAG_W)) u_abs_a (
    .i_value (data_operandA),
    .i_abs   (1'b1),
    .i_neg   (1'b0),
    .o_sign  (w_sign_a),
    .o_value (w_mag_a)
  );

  multdiv_abs_neg #(.W(WIDTH), .OUT_W(MAG_W)) u_abs_b (
    .i_value (data_operandB),
    .i_abs   (1'b1),
    .i_neg   (1'b0),
    .o_sign  (w_sign_b),
    .o_value (w_mag_b)
  );

  multdiv_abs_neg #(.W(WIDTH), .OUT_W(WIDTH)) u_neg_res (
    .i_value (w_mag_res),
    .i_abs   (1'b0),
    .i_neg   (r_sign),
    .o_sign  (w_res_sign),
    .o_value (w_res)
  );

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_cnt == CNT_W'(ITERS - 1));
  assign w_dz    = (r_mag_b == '0);

  assign w_acc_mul = r_acc + (r_mag_b[r_cnt] ? (ACC_W'(r_mag_a) << r_cnt) : '0);

  // Dividend bits are consumed MSB first; a borrow out of the trial subtract means "restore".
  assign w_div_idx  = CNT_W'(WIDTH - 1) - r_cnt;
  assign w_rem_sh   = {r_rem, r_mag_a[w_div_idx]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_mag_b};
  assign w_q_bit    = ~w_rem_diff[MAG_W];
  assign w_rem_nxt  = w_q_bit ? w_rem_diff[MAG_W-1:0] : w_rem_sh[MAG_W-1:0];
  assign w_acc_div  = {r_acc[ACC_W-2:0], w_q_bit};

  assign w_mag_res = (r_state == MULT) ? w_acc_mul[WIDTH-1:0] : w_acc_div[WIDTH-1:0];

  // A negative product may reach magnitude 2^(WIDTH-1); a positive one may not.
  assign w_mul_ovf = (|w_acc_mul[ACC_W-1:WIDTH]) |
                     (w_res_sign ? (w_acc_mul[WIDTH-1] & (|w_acc_mul[WIDTH-2:0]))
                                 : w_acc_mul[WIDTH-1]);
  assign w_div_ovf = ~w_res_sign & w_acc_div[WIDTH-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (ctrl_MULT) begin
      w_state_nxt = MULT;
    end else if (ctrl_DIV) begin
      w_state_nxt = DIV;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        MULT:    if (w_last) w_state_nxt = DONE;
        DIV:     if (w_dz || w_last) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_rem    <= '0;
      r_sign   <= 1'b0;
      r_acc    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_start) begin
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_sign  <= w_sign_a ^ w_sign_b;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        MULT: begin
          r_acc <= w_acc_mul;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_result <= w_res;
            r_exc    <= w_mul_ovf;
          end
        end
        DIV: begin
          if (w_dz) begin
            r_result <= '0;
            r_exc    <= 1'b1;
          end else begin
            r_acc <= w_acc_div;
            r_rem <= w_rem_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= w_res;
              r_exc    <= w_div_ovf;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = (r_state == DONE);
  assign busy           = (r_state == MULT) || (r_state == DIV);

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// Module : tb_multdiv_unit
// Brief  : Self-checking bench: vector table, directed corner cases, random vs model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_unit dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    bit          mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_r;
    bit          exp_e;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: true signed arithmetic on 64-bit integers.
  task automatic model(input bit mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit e, output int lat);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lat = 32;
    if (mult) begin
      p = sa * sb;
      r = p[31:0];
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (sb == 0) begin
      r = 32'h0; e = 1'b1; lat = 1;
    end else begin
      p = sa / sb;
      r = p[31:0];
      e = (p > 64'sd2147483647);
    end
  endtask

  task automatic start_op(input bit mult, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = mult;
    ctrl_DIV      = !mult;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Called on the negedge after the start edge; lat counts further cycles until RDY.
  task automatic wait_rdy(input int limit, output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 0; k <= limit; k++) begin
      if (data_resultRDY) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic do_op(input string tag, input bit mult, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r,
                       input bit exp_e, input int exp_lat);
    int lat;
    bit busy_ok;
    logic [31:0] r;
    logic e;
    start_op(mult, a, b);
    wait_rdy(80, lat, busy_ok);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    if (lat >= 0) begin
      r = data_result;
      e = data_exception;
      check({tag, "_result"}, 64'(r), 64'(exp_r));
      check({tag, "_exception"}, 64'(e), 64'(exp_e));
      check({tag, "_busy"}, 64'(busy_ok), 64'(1));
      @(negedge clock);
      check({tag, "_rdy_pulse"}, 64'(data_resultRDY), 64'(0));
      check({tag, "_held"}, {data_exception, data_result}, {e, r});
    end
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    bit busy_ok;
    int rdy_seen;
    logic [31:0] ra, rb, mr;
    bit me, mult;
    int ml;

    vecs[0] = '{1'b1, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 32};
    vecs[1] = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 32};
    vecs[2] = '{1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 32};
    vecs[3] = '{1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 32};
    vecs[4] = '{1'b0, 32'd100,        32'd7,         32'd14,        1'b0, 32};
    vecs[5] = '{1'b0, 32'd5,          32'd0,         32'd0,         1'b1, 1};
    vecs[6] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32};
    vecs[7] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32};
    vecs[8] = '{1'b1, 32'hFFFF_8000,  32'h0001_0000, 32'h8000_0000, 1'b0, 32};

    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    check("reset_result", 64'(data_result), 64'(0));
    check("reset_exception", 64'(data_exception), 64'(0));
    check("reset_rdy", 64'(data_resultRDY), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    reset_n = 1'b1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].mult, vecs[i].a, vecs[i].b,
            vecs[i].exp_r, vecs[i].exp_e, vecs[i].exp_lat);

    // Abort a multiply mid-flight with a divide.
    rdy_seen = 0;
    start_op(1'b1, 32'd3, 32'd3);
    repeat (9) begin
      if (data_resultRDY) rdy_seen++;
      @(negedge clock);
    end
    check("abort_no_mult_rdy", 64'(rdy_seen), 64'(0));
    do_op("abort_div", 1'b0, 32'd100, 32'd7, 32'd14, 1'b0, 32);

    // Asynchronous reset in the middle of a divide.
    start_op(1'b0, 32'd123456, 32'd789);
    repeat (19) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", {data_result, data_exception, data_resultRDY, busy}, 35'h0);
    @(negedge clock);
    reset_n = 1'b1;
    do_op("after_reset", 1'b1, 32'd9, 32'd9, 32'd81, 1'b0, 32);

    // New start on the edge that leaves DONE.
    start_op(1'b1, 32'd7, 32'hFFFF_FFFA);
    wait_rdy(80, lat, busy_ok);
    check("b2b_first_latency", 64'(lat), 64'(32));
    check("b2b_first_result", 64'(data_result), 64'(32'hFFFF_FFD6));
    ctrl_DIV = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    check("b2b_rdy_not_extended", 64'(data_resultRDY), 64'(0));
    check("b2b_busy", 64'(busy), 64'(1));
    wait_rdy(80, lat, busy_ok);
    check("b2b_second_latency", 64'(lat), 64'(32));
    check("b2b_second_result", 64'(data_result), 64'(14));

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      mult = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = 32'($signed($urandom_range(0, 200)) - 100);
        2: ra = 32'h8000_0000;
        default: ra = $urandom & 32'h0000_FFFF;
      endcase
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = 32'($signed($urandom_range(0, 40)) - 20);
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'h0;
        default: rb = $urandom & 32'h0000_0FFF;
      endcase
      model(mult, ra, rb, mr, me, ml);
      do_op($sformatf("rand%0d_%s_%h_%h", i, mult ? "mul" : "div", ra, rb),
            mult, ra, rb, mr, me, ml);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
